// File: rtl/sm_seq_multiplier.sv
// Sequential sign-magnitude multiplier, shift-add, one multiplier bit per cycle.
// Latency: M edges from accept to o_out_valid (EARLY_EXIT=1: 0..M, data dependent).
// Backpressure: result held in DONE until o_out_valid && i_out_ready; no new operands meanwhile.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous, active-high reset
//   i_in_valid   operands i_a / i_b valid
//   o_in_ready   block can accept operands (high only in IDLE)
//   i_a          multiplicand {sign, magnitude}, WIDTH bits
//   i_b          multiplier   {sign, magnitude}, WIDTH bits
//   o_out_valid  o_product / o_zero_flag valid
//   i_out_ready  consumer accepts the result
//   o_product    {sign, 2M-bit magnitude}, M = WIDTH-1
//   o_zero_flag  product magnitude is zero
//
// Operands use the MSB as sign and the remaining M bits as magnitude. The
// magnitude product is accumulated in a 2M-bit register; (2^M-1)^2 always
// fits, so no overflow handling is needed. A zero magnitude always produces a
// positive sign, so the block never emits a negative zero.

module sm_seq_multiplier #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [WIDTH-1:0]       i_a,
  input  logic [WIDTH-1:0]       i_b,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [2*(WIDTH-1):0]   o_product,
  output logic                   o_zero_flag
);

  localparam int M  = WIDTH - 1;
  localparam int PW = 2 * M;
  // Counter only has to reach M-1; M >= 2 keeps this at least one bit.
  localparam int CW = $clog2(M);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [M-1:0]    r_mcand;
  logic [M-1:0]    r_mplier;
  logic            r_sign;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [PW:0]     r_product;
  logic            r_zero_flag;
  logic            r_out_valid;
  logic            r_in_ready;

  logic [PW-1:0]   w_mcand_ext;
  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_acc_next;
  logic [M-1:0]    w_mplier_next;
  logic            w_last;
  logic            w_accept;
  logic            w_zero_op;
  logic            w_res_sign;

  assign w_mcand_ext   = {{M{1'b0}}, r_mcand};
  // Partial product for the multiplier bit currently at r_mplier[0].
  assign w_addend      = r_mplier[0] ? (w_mcand_ext << r_cnt) : '0;
  assign w_acc_next    = r_acc + w_addend;
  assign w_mplier_next = r_mplier >> 1;

  // Last CALC step: all M bits consumed, or (early exit) nothing left to add.
  assign w_last = (r_cnt == CW'(M - 1)) ||
                  (EARLY_EXIT && (w_mplier_next == '0));

  assign w_accept   = i_in_valid && r_in_ready;
  assign w_zero_op  = (i_a[M-1:0] == '0) || (i_b[M-1:0] == '0);
  // Sign is suppressed on a zero result so -0 never leaves the block.
  assign w_res_sign = r_sign && (w_acc_next != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_sign      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_zero_flag <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand    <= i_a[M-1:0];
            r_mplier   <= i_b[M-1:0];
            r_sign     <= i_a[M] ^ i_b[M];
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            if (EARLY_EXIT && w_zero_op) begin
              // Result is known to be +0 without iterating.
              r_state     <= S_DONE;
              r_product   <= '0;
              r_zero_flag <= 1'b1;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          r_acc    <= w_acc_next;
          r_mplier <= w_mplier_next;
          if (w_last) begin
            r_state     <= S_DONE;
            r_product   <= {w_res_sign, w_acc_next};
            r_zero_flag <= (w_acc_next == '0);
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          // Product and zero flag stay untouched here, so they are stable
          // under backpressure and keep their value after the handshake.
          if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_product   = r_product;
  assign o_zero_flag = r_zero_flag;

endmodule

// File: tb/tb_sm_seq_multiplier.sv
// Directed bench for sm_seq_multiplier, WIDTH=8 (M=7).
// Instance 0 runs with EARLY_EXIT=0, instance 1 with EARLY_EXIT=1.
// Inputs driven and outputs sampled on the falling edge.

module tb_sm_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  a         [2];
  logic [7:0]  b         [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [14:0] product   [2];
  logic        zero_flag [2];

  int n_checks;
  int n_errors;

  sm_seq_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut0 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid[0]),
    .o_in_ready  (in_ready[0]),
    .i_a         (a[0]),
    .i_b         (b[0]),
    .o_out_valid (out_valid[0]),
    .i_out_ready (out_ready[0]),
    .o_product   (product[0]),
    .o_zero_flag (zero_flag[0])
  );

  sm_seq_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut1 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid[1]),
    .o_in_ready  (in_ready[1]),
    .i_a         (a[1]),
    .i_b         (b[1]),
    .o_out_valid (out_valid[1]),
    .i_out_ready (out_ready[1]),
    .o_product   (product[1]),
    .o_zero_flag (zero_flag[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one edge; returns at the falling edge after the
  // accept edge.
  task automatic start_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready[sel]), 32'd1);
    a[sel]        = av;
    b[sel]        = bv;
    in_valid[sel] = 1'b1;
    @(negedge clk);
    in_valid[sel] = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen; 0 means the
  // result was already valid right after the accept edge.
  task automatic wait_done(input int sel, output int lat);
    lat = 0;
    while (!out_valid[sel] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op(input int sel, input string tag);
    out_ready[sel] = 1'b1;
    @(negedge clk);
    out_ready[sel] = 1'b0;
    check({tag, "_vld_drop"}, 32'(out_valid[sel]), 32'd0);
    check({tag, "_idle"},     32'(in_ready[sel]),  32'd1);
  endtask

  task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input int exp_lat, input logic [14:0] exp_prod,
                        input logic exp_zf, input string tag);
    int lat;
    start_op(sel, av, bv, tag);
    wait_done(sel, lat);
    check({tag, "_lat"},  32'(lat),            32'(exp_lat));
    check({tag, "_prod"}, 32'(product[sel]),   32'(exp_prod));
    check({tag, "_zf"},   32'(zero_flag[sel]), 32'(exp_zf));
    finish_op(sel, tag);
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      a[i]         = '0;
      b[i]         = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  32'(in_ready[0]),  32'd1);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_product",   32'(product[0]),   32'd0);
    check("rst_zero_flag", 32'(zero_flag[0]), 32'd0);
    check("rst_in_ready1", 32'(in_ready[1]),  32'd1);

    // EARLY_EXIT=0: 5 * -3 = -15, then hold the result under backpressure
    // while a second operand pair is offered and must be ignored.
    start_op(0, 8'h05, 8'h83, "hold");
    wait_done(0, lat);
    check("hold_lat",  32'(lat),          32'd7);
    check("hold_prod", 32'(product[0]),   32'h400F);
    check("hold_zf",   32'(zero_flag[0]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      a[0]        = 8'h7F;
      b[0]        = 8'hFF;
      in_valid[0] = 1'b1;
      @(negedge clk);
      check("hold_stable_prod", 32'(product[0]),   32'h400F);
      check("hold_in_ready",    32'(in_ready[0]),  32'd0);
      check("hold_out_valid",   32'(out_valid[0]), 32'd1);
    end
    in_valid[0] = 1'b0;
    finish_op(0, "hold");
    check("hold_after_hs_prod", 32'(product[0]), 32'h400F);
    // Nothing was accepted during the hold: block stays idle.
    @(negedge clk);
    check("hold_no_new_op", 32'(in_ready[0]), 32'd1);

    // EARLY_EXIT=0: fixed latency of 7 regardless of data
    run_op(0, 8'h7F, 8'hFF, 7, 15'h7F01, 1'b0, "max_neg");
    run_op(0, 8'h80, 8'h05, 7, 15'h0000, 1'b1, "neg_zero");
    run_op(0, 8'h83, 8'h85, 7, 15'h000F, 1'b0, "neg_neg");
    run_op(0, 8'h7F, 8'h01, 7, 15'h007F, 1'b0, "by_one");

    // Reset in the 3rd CALC cycle abandons the operation
    start_op(0, 8'h05, 8'h83, "rst_calc");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstc_in_ready",  32'(in_ready[0]),  32'd1);
    check("rstc_out_valid", 32'(out_valid[0]), 32'd0);
    check("rstc_product",   32'(product[0]),   32'd0);
    check("rstc_zero_flag", 32'(zero_flag[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("rstc_no_output", 32'(out_valid[0]), 32'd0);
    run_op(0, 8'h7F, 8'hFF, 7, 15'h7F01, 1'b0, "after_rst");

    // EARLY_EXIT=1: latency follows the highest set bit of b's magnitude;
    // a zero magnitude goes straight to DONE on the accept edge.
    run_op(1, 8'h05, 8'h03, 2, 15'h000F, 1'b0, "ee_5x3");
    run_op(1, 8'h05, 8'h00, 0, 15'h0000, 1'b1, "ee_b_zero");
    run_op(1, 8'h00, 8'h40, 0, 15'h0000, 1'b1, "ee_a_zero");
    run_op(1, 8'h80, 8'h05, 0, 15'h0000, 1'b1, "ee_neg_zero");
    run_op(1, 8'h03, 8'h40, 7, 15'h00C0, 1'b0, "ee_msb");
    run_op(1, 8'h85, 8'h02, 2, 15'h400A, 1'b0, "ee_neg");
    run_op(1, 8'h7F, 8'hFF, 7, 15'h7F01, 1'b0, "ee_max");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
